// File: rtl/gameclk.sv
// Game tick generator: divides clk down to a 50% duty clk_out whose half-period
// shortens on every level-up, and tightens the obstacle gap minEmpty alongside.
module gameclk #(
    parameter int unsigned DIV_INIT        = 2_500_000,
    parameter int unsigned DIV_MIN         = 1_000_000,
    parameter int unsigned DIV_STEP        = 100_000,
    parameter int unsigned TICKS_PER_LEVEL = 500,
    parameter logic [8:0]  EMPTY_INIT      = 9'd400,
    parameter logic [8:0]  EMPTY_MIN       = 9'd120,
    parameter logic [8:0]  EMPTY_STEP      = 9'd20
) (
    input  logic       clk,
    input  logic       rst,
    output logic       clk_out,
    output logic [8:0] minEmpty
);

    localparam logic [31:0] DivInit  = 32'(DIV_INIT);
    localparam logic [31:0] DivMin   = 32'(DIV_MIN);
    localparam logic [31:0] DivStep  = 32'(DIV_STEP);
    localparam logic [15:0] TickLast = 16'(TICKS_PER_LEVEL - 1);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] per_q, per_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic        clk_out_q, clk_out_d;
    logic [8:0]  min_empty_q, min_empty_d;

    // Next-state: divider, tick counter and saturating level-up.
    always_comb begin
        cnt_d       = cnt_q + 32'd1;
        per_d       = per_q;
        tcnt_d      = tcnt_q;
        clk_out_d   = clk_out_q;
        min_empty_d = min_empty_q;

        // >= rather than == so an overshooting cnt still toggles.
        if (cnt_q >= per_q - 32'd1) begin
            cnt_d     = 32'd0;
            clk_out_d = ~clk_out_q;
            if (!clk_out_q) begin
                if (tcnt_q < TickLast) begin
                    tcnt_d = tcnt_q + 16'd1;
                end else begin
                    tcnt_d = 16'd0;
                    // Saturate at the floor, guarding against unsigned underflow.
                    if (per_q < DivStep || (per_q - DivStep) < DivMin) begin
                        per_d = DivMin;
                    end else begin
                        per_d = per_q - DivStep;
                    end
                    if (min_empty_q < EMPTY_STEP || (min_empty_q - EMPTY_STEP) < EMPTY_MIN) begin
                        min_empty_d = EMPTY_MIN;
                    end else begin
                        min_empty_d = min_empty_q - EMPTY_STEP;
                    end
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 32'd0;
            per_q       <= DivInit;
            tcnt_q      <= 16'd0;
            clk_out_q   <= 1'b0;
            min_empty_q <= EMPTY_INIT;
        end else begin
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            tcnt_q      <= tcnt_d;
            clk_out_q   <= clk_out_d;
            min_empty_q <= min_empty_d;
        end
    end

    assign clk_out  = clk_out_q;
    assign minEmpty = min_empty_q;

endmodule

// File: tb/tb_gameclk.sv
// Directed bench for gameclk: expected toggle events are queued and popped as
// the edge counter reaches them; every other edge must hold clk_out/minEmpty.
module tb_gameclk;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_out;
    logic [8:0] min_empty;
    logic       clk_out_def;
    logic [8:0] min_empty_def;

    always #5 clk = ~clk;

    gameclk #(
        .DIV_INIT        (4),
        .DIV_MIN         (2),
        .DIV_STEP        (1),
        .TICKS_PER_LEVEL (2),
        .EMPTY_INIT      (9'd300),
        .EMPTY_MIN       (9'd100),
        .EMPTY_STEP      (9'd90)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_out  (clk_out),
        .minEmpty (min_empty)
    );

    gameclk dut_def (
        .clk      (clk),
        .rst      (rst),
        .clk_out  (clk_out_def),
        .minEmpty (min_empty_def)
    );

    typedef struct {
        int         edge_n;
        logic       clk_v;
        logic [8:0] me;
    } ev_t;

    ev_t        sb[$];
    int         total    = 0;
    int         passed   = 0;
    int         edge_cnt = 0;
    logic       exp_clk  = 1'b0;
    logic [8:0] exp_me   = 9'd300;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_cnt, obs, exp);
        end
    endtask

    task automatic push(input int e, input logic c, input logic [8:0] m);
        ev_t ev;
        ev.edge_n = e;
        ev.clk_v  = c;
        ev.me     = m;
        sb.push_back(ev);
    endtask

    // Advance n edges, comparing against the queue head or the held value.
    task automatic run_edges(input int n);
        ev_t ev;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_cnt++;
            if (sb.size() > 0 && sb[0].edge_n == edge_cnt) begin
                ev      = sb.pop_front();
                exp_clk = ev.clk_v;
                exp_me  = ev.me;
                chk("toggle_clk", 32'(clk_out), 32'(exp_clk));
                chk("toggle_me", 32'(min_empty), 32'(exp_me));
            end else begin
                chk("hold_clk", 32'(clk_out), 32'(exp_clk));
                chk("hold_me", 32'(min_empty), 32'(exp_me));
            end
        end
    endtask

    task automatic restart_model();
        sb.delete();
        edge_cnt = 0;
        exp_clk  = 1'b0;
        exp_me   = 9'd300;
    endtask

    initial begin
        // Scenario 1: two reset cycles.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_clk", 32'(clk_out), 32'd0);
            chk("rst_me", 32'(min_empty), 32'd300);
        end
        chk("def_rst_clk", 32'(clk_out_def), 32'd0);
        chk("def_rst_me", 32'(min_empty_def), 32'd400);
        rst = 1'b0;

        // Scenarios 1-3: free run through two level-ups into saturation.
        restart_model();
        push(4, 1'b1, 9'd300);
        push(8, 1'b0, 9'd300);
        push(12, 1'b1, 9'd210);
        push(15, 1'b0, 9'd210);
        push(18, 1'b1, 9'd210);
        push(21, 1'b0, 9'd210);
        push(24, 1'b1, 9'd120);
        push(26, 1'b0, 9'd120);
        push(28, 1'b1, 9'd120);
        push(30, 1'b0, 9'd120);
        push(32, 1'b1, 9'd100);
        push(34, 1'b0, 9'd100);
        push(36, 1'b1, 9'd100);
        push(38, 1'b0, 9'd100);
        push(40, 1'b1, 9'd100);
        run_edges(41);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Scenario 4: fresh start, then reset on edge 20 mid-level.
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_clk", 32'(clk_out), 32'd0);
        chk("rst2_me", 32'(min_empty), 32'd300);
        rst = 1'b0;
        restart_model();
        push(4, 1'b1, 9'd300);
        push(8, 1'b0, 9'd300);
        push(12, 1'b1, 9'd210);
        push(15, 1'b0, 9'd210);
        push(18, 1'b1, 9'd210);
        run_edges(19);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_clk", 32'(clk_out), 32'd0);
        chk("midrst_me", 32'(min_empty), 32'd300);
        rst = 1'b0;
        restart_model();
        push(4, 1'b1, 9'd300);
        push(8, 1'b0, 9'd300);
        push(12, 1'b1, 9'd210);
        run_edges(12);

        // Default instance: far from its first toggle, outputs still at reset value.
        chk("def_run_clk", 32'(clk_out_def), 32'd0);
        chk("def_run_me", 32'(min_empty_def), 32'd400);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout edge=%0d", edge_cnt);
        $fatal(1, "timeout");
    end

endmodule
